seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for an NDIG-digit common-select 7-segment display.

---
 rtl/seg_pkg.sv | 22 ++
 rtl/seg7_dec.sv | 27 ++
 rtl/seg_scan_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan controller: segment codes and FSM state encoding.
package seg_pkg;

  // Segment order is {a,b,c,d,e,f,g}; a set bit lights the segment.
  localparam logic [6:0] SEG_0   = 7'b1111110;
  localparam logic [6:0] SEG_1   = 7'b0110000;
  localparam logic [6:0] SEG_2   = 7'b1101101;
  localparam logic [6:0] SEG_3   = 7'b1111001;
  localparam logic [6:0] SEG_4   = 7'b0110011;
  localparam logic [6:0] SEG_5   = 7'b1011011;
  localparam logic [6:0] SEG_6   = 7'b1011111;
  localparam logic [6:0] SEG_7   = 7'b1110000;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1111011;
  localparam logic [6:0] SEG_ERR = 7'b1100011;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHOW  = 2'd1;
  localparam logic [1:0] BLANK = 2'd2;

endpackage

// File: rtl/seg7_dec.sv
// Combinational 4-bit value to 7-segment code decoder; values 10..15 show the error glyph.
module seg7_dec
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Value to segment pattern lookup
  always_comb begin
    seg = SEG_ERR;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_ERR;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with double-buffered digit store,
// inter-digit blanking, frame-synchronous commit and leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIG      = 8,
  parameter int DIV       = 65536,
  parameter int BLANK_CYC = 16
) (
  input  logic            CP,
  input  logic            nCR,
  input  logic            ENABLE,
  input  logic            WR_EN,
  input  logic [2:0]      WR_ADDR,
  input  logic [3:0]      WR_DATA,
  input  logic            COMMIT,
  input  logic            LZB,
  output logic [2:0]      DIG_SEL,
  output logic [NDIG-1:0] DIG_EN,
  output logic [6:0]      SEG,
  output logic            FRAME,
  output logic            PEND
);

  localparam int CNT_MAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [2:0]    IDX_LAST   = 3'(NDIG - 1);

  logic [1:0]      state_r;
  logic [1:0]      state_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_s;
  logic [2:0]      idx_r;
  logic [2:0]      idx_s;
  logic            wrap_s;
  logic            copy_s;
  logic            show_s;
  logic            dark_s;
  logic [7:0]      lead_zero_s;
  logic [6:0]      dec_seg_s;
  logic [NDIG-1:0] onehot_s;
  logic            pend_r;
  logic            frame_r;
  logic [2:0]      dig_sel_r;
  logic [NDIG-1:0] dig_en_r;
  logic [6:0]      seg_r;
  // Stores are sized for the full 3-bit index; entries at or above NDIG are never written and stay 0.
  logic [3:0]      shadow_r  [8];
  logic [3:0]      display_r [8];

  // Next state, phase counter and digit index; ENABLE low parks everything in IDLE
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    wrap_s  = 1'b0;
    if (!ENABLE) begin
      state_s = IDLE;
      cnt_s   = {CW{1'b0}};
      idx_s   = 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = SHOW;
          cnt_s   = {CW{1'b0}};
          idx_s   = 3'd0;
        end
        SHOW: begin
          if (cnt_r == SHOW_LAST) begin
            state_s = BLANK;
            cnt_s   = {CW{1'b0}};
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        BLANK: begin
          if (cnt_r == BLANK_LAST) begin
            state_s = SHOW;
            cnt_s   = {CW{1'b0}};
            if (idx_r == IDX_LAST) begin
              idx_s  = 3'd0;
              wrap_s = 1'b1;
            end else begin
              idx_s = idx_r + 3'd1;
            end
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = {CW{1'b0}};
          idx_s   = 3'd0;
        end
      endcase
    end
  end

  // Copy happens at the frame wrap, or immediately when no frame is running
  assign copy_s   = pend_r && (wrap_s || (state_r == IDLE));
  assign show_s   = ENABLE && (state_r == SHOW);
  assign onehot_s = {{(NDIG-1){1'b0}}, 1'b1} << idx_r;

  // Leading-zero run from the most significant digit downward
  always_comb begin
    logic zero_run;
    zero_run    = 1'b1;
    lead_zero_s = 8'd0;
    for (int i = 7; i >= 0; i--) begin
      zero_run       = zero_run && (display_r[i] == 4'd0);
      lead_zero_s[i] = zero_run;
    end
  end

  assign dark_s = LZB && (idx_r != 3'd0) && lead_zero_s[idx_r];

  seg7_dec u_dec (
    .digit (display_r[idx_r]),
    .seg   (dec_seg_s)
  );

  // FSM state, phase counter and index registers
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      idx_r   <= 3'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
    end
  end

  // Shadow/display stores and pending-commit flag; a write on the copy edge is not copied
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      for (int i = 0; i < 8; i++) begin
        shadow_r[i]  <= 4'd0;
        display_r[i] <= 4'd0;
      end
      pend_r <= 1'b0;
    end else begin
      if (copy_s) begin
        for (int i = 0; i < 8; i++) begin
          display_r[i] <= shadow_r[i];
        end
        pend_r <= COMMIT;
      end else begin
        pend_r <= pend_r | COMMIT;
      end
      if (WR_EN && (WR_ADDR <= IDX_LAST)) begin
        shadow_r[WR_ADDR] <= WR_DATA;
      end
    end
  end

  // Registered pin drivers; ENABLE low darkens the display on the same edge the FSM parks
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      dig_sel_r <= 3'd0;
      dig_en_r  <= {NDIG{1'b0}};
      seg_r     <= SEG_OFF;
      frame_r   <= 1'b0;
    end else begin
      frame_r <= wrap_s;
      if (show_s) begin
        dig_sel_r <= idx_r;
        dig_en_r  <= onehot_s;
        seg_r     <= dark_s ? SEG_OFF : dec_seg_s;
      end else begin
        dig_en_r <= {NDIG{1'b0}};
        seg_r    <= SEG_OFF;
      end
    end
  end

  assign DIG_SEL = dig_sel_r;
  assign DIG_EN  = dig_en_r;
  assign SEG     = seg_r;
  assign FRAME   = frame_r;
  assign PEND    = pend_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus random traffic against a
// frame-position reference model (position within the frame decides digit and show/blank).
module tb_seg_scan_ctrl;

  localparam int NDIG      = 4;
  localparam int DIV       = 4;
  localparam int BLANK_CYC = 2;
  localparam int PER       = DIV + BLANK_CYC;
  localparam int FRM       = PER * NDIG;
  localparam logic [6:0] TAB [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                      7'b1111111, 7'b1111011, 7'b1100011, 7'b1100011,
                                      7'b1100011, 7'b1100011, 7'b1100011, 7'b1100011};

  logic            CP = 1'b0;
  logic            nCR, ENABLE, WR_EN, COMMIT, LZB;
  logic [2:0]      WR_ADDR;
  logic [3:0]      WR_DATA;
  logic [2:0]      DIG_SEL;
  logic [NDIG-1:0] DIG_EN;
  logic [6:0]      SEG;
  logic            FRAME, PEND;

  int checks = 0;
  int failures = 0;

  // Reference model: m_p is the cycle position within the running frame
  logic            m_run, m_pend;
  int              m_p;
  logic [3:0]      m_shadow [8];
  logic [3:0]      m_disp   [8];
  logic [2:0]      e_sel;
  logic [NDIG-1:0] e_en;
  logic [6:0]      e_seg;
  logic            e_frame;
  logic [15:0]     obs, expv;

  assign obs  = {DIG_SEL, DIG_EN, SEG, FRAME, PEND};
  assign expv = {e_sel, e_en, e_seg, e_frame, m_pend};

  seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .CP(CP), .nCR(nCR), .ENABLE(ENABLE), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA), .COMMIT(COMMIT), .LZB(LZB), .DIG_SEL(DIG_SEL),
    .DIG_EN(DIG_EN), .SEG(SEG), .FRAME(FRAME), .PEND(PEND)
  );

  always #5 CP = ~CP;

  function automatic bit show_now();
    return m_run && ((m_p % PER) < DIV);
  endfunction

  function automatic logic [2:0] idx_now();
    return 3'((m_p / PER) % NDIG);
  endfunction

  function automatic bit wrap_now();
    return ENABLE && m_run && (m_p == FRM - 1);
  endfunction

  function automatic bit dark_now();
    int i;
    i = int'(idx_now());
    if (!LZB || i == 0) return 1'b0;
    for (int j = i; j < NDIG; j++) if (m_disp[3'(j)] != 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      m_run <= 1'b0; m_p <= 0; m_pend <= 1'b0;
      e_sel <= 3'd0; e_en <= '0; e_seg <= 7'd0; e_frame <= 1'b0;
      for (int i = 0; i < 8; i++) begin m_shadow[i] <= 4'd0; m_disp[i] <= 4'd0; end
    end else begin
      if (ENABLE && show_now()) begin
        e_sel <= idx_now();
        e_en  <= {{(NDIG-1){1'b0}}, 1'b1} << idx_now();
        e_seg <= dark_now() ? 7'd0 : TAB[m_disp[idx_now()]];
      end else begin
        e_en  <= '0;
        e_seg <= 7'd0;
      end
      e_frame <= wrap_now();
      if (m_pend && (wrap_now() || !m_run)) begin
        for (int i = 0; i < 8; i++) m_disp[i] <= m_shadow[i];
        m_pend <= COMMIT;
      end else begin
        m_pend <= m_pend || COMMIT;
      end
      if (WR_EN && (int'(WR_ADDR) < NDIG)) m_shadow[WR_ADDR] <= WR_DATA;
      m_run <= ENABLE;
      m_p   <= (ENABLE && m_run) ? (m_p + 1) % FRM : 0;
    end
  end

  task automatic test_reset();
    nCR = 1'b0; ENABLE = 1'b0; WR_EN = 1'b0; WR_ADDR = 3'd0; WR_DATA = 4'd0;
    COMMIT = 1'b0; LZB = 1'b0;
    repeat (2) @(negedge CP);
    checks++; if (obs !== 16'h0000) begin failures++; $display("FAIL reset_out got=%h exp=0000", obs); end
    nCR = 1'b1;
    @(negedge CP);
    checks++; if (obs !== expv) begin failures++; $display("FAIL reset_idle got=%h exp=%h", obs, expv); end
  endtask

  task automatic test_scan_zero();
    int last, frames;
    last = -1; frames = 0;
    ENABLE = 1'b1;
    for (int c = 0; c < 4 * FRM; c++) begin
      @(negedge CP);
      checks++; if (obs !== expv) begin failures++; $display("FAIL scan_zero c=%0d got=%h exp=%h", c, obs, expv); end
      if (DIG_EN != 4'b0000) begin
        checks++; if (SEG !== 7'b1111110) begin failures++; $display("FAIL scan_zero_seg got=%b exp=1111110", SEG); end
      end
      if (FRAME) begin
        frames++;
        if (last >= 0) begin
          checks++; if (c - last != FRM) begin failures++; $display("FAIL frame_period got=%0d exp=%0d", c - last, FRM); end
        end
        last = c;
      end
    end
    checks++; if (frames < 3) begin failures++; $display("FAIL frame_count got=%0d exp>=3", frames); end
  endtask

  task automatic test_frame_load(input logic [15:0] vals, input logic lzb, input logic [27:0] want);
    int frames, k;
    frames = 0;
    LZB = lzb;
    for (int i = 0; i < NDIG; i++) begin
      @(negedge CP);
      checks++; if (obs !== expv) begin failures++; $display("FAIL load_wr got=%h exp=%h", obs, expv); end
      WR_EN = 1'b1; WR_ADDR = 3'(i); WR_DATA = vals[4*i +: 4];
    end
    @(negedge CP);
    checks++; if (obs !== expv) begin failures++; $display("FAIL load_wr5 got=%h exp=%h", obs, expv); end
    WR_ADDR = 3'd5; WR_DATA = 4'($urandom_range(15, 0));
    @(negedge CP);
    checks++; if (obs !== expv) begin failures++; $display("FAIL load_commit got=%h exp=%h", obs, expv); end
    WR_EN = 1'b0; COMMIT = 1'b1;
    @(negedge CP);
    COMMIT = 1'b0;
    checks++; if (PEND !== 1'b1) begin failures++; $display("FAIL load_pend got=%b exp=1", PEND); end
    for (int c = 0; c < 2 * FRM + 4; c++) begin
      @(negedge CP);
      checks++; if (obs !== expv) begin failures++; $display("FAIL load_scan got=%h exp=%h", obs, expv); end
      if (FRAME) frames++;
      if (frames > 0 && DIG_EN != 4'b0000) begin
        k = int'(DIG_SEL);
        checks++; if (SEG !== want[7*k +: 7]) begin failures++; $display("FAIL load_digit%0d got=%b exp=%b", k, SEG, want[7*k +: 7]); end
      end
    end
    checks++; if (frames < 1 || PEND !== 1'b0) begin failures++; $display("FAIL load_copy frames=%0d pend=%b exp frames>=1 pend=0", frames, PEND); end
  endtask

  task automatic test_commit_on_frame();
    int n;
    n = 0;
    LZB = 1'b0;
    @(negedge CP);
    checks++; if (obs !== expv) begin failures++; $display("FAIL cof_start got=%h exp=%h", obs, expv); end
    COMMIT = 1'b1;
    do begin
      @(negedge CP); COMMIT = 1'b0; n++;
      checks++; if (obs !== expv) begin failures++; $display("FAIL cof_wait got=%h exp=%h", obs, expv); end
    end while (!(m_run && m_p == FRM - 1) && n < 3 * FRM);
    checks++; if (n >= 3 * FRM) begin failures++; $display("FAIL cof_timeout got=%0d exp<%0d", n, 3 * FRM); end
    COMMIT = 1'b1; WR_EN = 1'b1; WR_ADDR = 3'd0; WR_DATA = 4'd5;
    @(negedge CP);
    COMMIT = 1'b0; WR_EN = 1'b0;
    checks++; if ({FRAME, PEND} !== 2'b11) begin failures++; $display("FAIL cof_keep got=%b%b exp=11", FRAME, PEND); end
    n = 0;
    do begin
      @(negedge CP); n++;
      checks++; if (obs !== expv) begin failures++; $display("FAIL cof_next got=%h exp=%h", obs, expv); end
    end while (!FRAME && n < 2 * FRM);
    checks++; if ({FRAME, PEND} !== 2'b10) begin failures++; $display("FAIL cof_second got=%b%b exp=10", FRAME, PEND); end
  endtask

  task automatic test_enable_drop();
    int n;
    n = 0;
    do begin
      @(negedge CP); n++;
      checks++; if (obs !== expv) begin failures++; $display("FAIL en_wait got=%h exp=%h", obs, expv); end
    end while (!(m_run && m_p == 2 * PER + 2) && n < 3 * FRM);
    checks++; if (n >= 3 * FRM) begin failures++; $display("FAIL en_timeout got=%0d exp<%0d", n, 3 * FRM); end
    ENABLE = 1'b0;
    @(negedge CP);
    checks++; if ({DIG_EN, SEG} !== 11'd0) begin failures++; $display("FAIL en_dark got=%b_%b exp=0", DIG_EN, SEG); end
    repeat (3) begin
      @(negedge CP);
      checks++; if (obs !== expv) begin failures++; $display("FAIL en_idle got=%h exp=%h", obs, expv); end
    end
    ENABLE = 1'b1;
    repeat (2) @(negedge CP);
    checks++; if ({DIG_SEL, DIG_EN} !== {3'd0, 4'b0001}) begin failures++; $display("FAIL en_restart got=%0d/%b exp=0/0001", DIG_SEL, DIG_EN); end
  endtask

  task automatic test_idle_commit();
    LZB = 1'b0; ENABLE = 1'b0;
    @(negedge CP);
    WR_EN = 1'b1; WR_ADDR = 3'd3; WR_DATA = 4'd8;
    @(negedge CP);
    WR_EN = 1'b0; COMMIT = 1'b1;
    @(negedge CP);
    COMMIT = 1'b0;
    checks++; if (PEND !== 1'b1) begin failures++; $display("FAIL idle_pend got=%b exp=1", PEND); end
    @(negedge CP);
    checks++; if (PEND !== 1'b0) begin failures++; $display("FAIL idle_copy got=%b exp=0", PEND); end
    ENABLE = 1'b1;
    repeat (FRM + 4) begin
      @(negedge CP);
      checks++; if (obs !== expv) begin failures++; $display("FAIL idle_scan got=%h exp=%h", obs, expv); end
      if (DIG_EN == 4'b1000) begin
        checks++; if (SEG !== 7'b1111111) begin failures++; $display("FAIL idle_digit3 got=%b exp=1111111", SEG); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    do begin
      @(negedge CP); n++;
      checks++; if (obs !== expv) begin failures++; $display("FAIL rst_wait got=%h exp=%h", obs, expv); end
    end while (!(m_run && (m_p % PER) == DIV) && n < 3 * FRM);
    COMMIT = 1'b1;
    @(negedge CP);
    COMMIT = 1'b0;
    checks++; if (PEND !== 1'b1 || DIG_EN !== 4'b0000) begin failures++; $display("FAIL rst_pre pend=%b en=%b exp 1/0000", PEND, DIG_EN); end
    #2 nCR = 1'b0;
    #1;
    checks++; if (obs !== 16'h0000) begin failures++; $display("FAIL rst_async got=%h exp=0000", obs); end
    @(negedge CP);
    #2 nCR = 1'b1;
    repeat (FRM + 6) begin
      @(negedge CP);
      checks++; if (obs !== expv) begin failures++; $display("FAIL rst_after got=%h exp=%h", obs, expv); end
      if (DIG_EN != 4'b0000) begin
        checks++; if (SEG !== 7'b1111110) begin failures++; $display("FAIL rst_cleared got=%b exp=1111110", SEG); end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      @(negedge CP);
      checks++; if (obs !== expv) begin failures++; $display("FAIL random c=%0d got=%h exp=%h", c, obs, expv); end
      ENABLE  = ($urandom_range(199, 0) != 0);
      WR_EN   = ($urandom_range(3, 0) == 0);
      WR_ADDR = 3'($urandom_range(7, 0));
      WR_DATA = 4'($urandom_range(15, 0));
      COMMIT  = ($urandom_range(15, 0) == 0);
      if ($urandom_range(63, 0) == 0) LZB = ~LZB;
    end
  endtask

  initial begin
    test_reset();
    test_scan_zero();
    test_frame_load(16'h9321, 1'b0, {7'b1111011, 7'b1111001, 7'b1101101, 7'b0110000});
    test_frame_load(16'h9C21, 1'b0, {7'b1111011, 7'b1100011, 7'b1101101, 7'b0110000});
    test_frame_load(16'h0700, 1'b1, {7'b0000000, 7'b1110000, 7'b1111110, 7'b1111110});
    test_frame_load(16'h0000, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110});
    test_commit_on_frame();
    test_enable_drop();
    test_idle_commit();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
